// File: rtl/detect_timer_pkg.sv
// Shared types and default sizes for the detection time-stamp / pulse-width block.
package detect_timer_pkg;

   // Default width of the free-running counter and of the captured time stamp.
   localparam int DEF_CNT_WIDTH = 32;

   // Default width of the pulse-length measurement.
   localparam int DEF_LEN_WIDTH = 16;

   // Measurement sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_HOLD    = 2'd2
   } state_e;

endpackage : detect_timer_pkg

// File: rtl/detect_timer_rise_detect.sv
// Rising-edge detector for the detect input: one delay register plus an AND gate.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic i_detect,
   output logic o_rise
);

   logic r_detect_q;

   // Remember the previous sample of detect so a low-to-high transition can be seen.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_detect_q <= 1'b0;
      end else begin
         r_detect_q <= i_detect;
      end
   end

   // A rise is a high sample whose previous sample was low.
   assign o_rise = i_detect & ~r_detect_q;

endmodule : rise_detect

// File: rtl/detect_timer.sv
// Time-stamps detection pulses against a free-running counter and measures their width.
// One result is held until acknowledged; pulses starting while a result is held are
// dropped and reported through the sticky overrun flag.
module detect_timer
   import detect_timer_pkg::*;
#(
   parameter int CNT_WIDTH = DEF_CNT_WIDTH,
   parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 detect,
   input  logic                 ack,
   output logic [CNT_WIDTH-1:0] time_out,
   output logic [LEN_WIDTH-1:0] len_out,
   output logic                 valid,
   output logic                 busy,
   output logic                 overrun
);

   // Saturating increment for the pulse-length counter: sticks at all-ones.
   function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
      logic [LEN_WIDTH-1:0] res;
      if (&v) begin
         res = v;
      end else begin
         res = v + LEN_WIDTH'(1);
      end
      return res;
   endfunction

   logic                 w_rise;
   logic [CNT_WIDTH-1:0] r_counter;
   state_e               r_state;
   state_e               w_state_nxt;
   logic [CNT_WIDTH-1:0] r_time_out;
   logic [CNT_WIDTH-1:0] w_time_nxt;
   logic [LEN_WIDTH-1:0] r_len_out;
   logic [LEN_WIDTH-1:0] w_len_nxt;
   logic                 r_valid;
   logic                 w_valid_nxt;
   logic                 r_busy;
   logic                 w_busy_nxt;
   logic                 r_overrun;
   logic                 w_overrun_nxt;

   rise_detect u_rise_detect (
      .clk      (clk),
      .rst      (rst),
      .i_detect (detect),
      .o_rise   (w_rise)
   );

   // Free-running time base; wraps naturally from all-ones to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_counter <= '0;
      end else begin
         r_counter <= r_counter + CNT_WIDTH'(1);
      end
   end

   // Next-state and next-output decode for the IDLE / MEASURE / HOLD sequencer.
   always_comb begin
      w_state_nxt   = r_state;
      w_time_nxt    = r_time_out;
      w_len_nxt     = r_len_out;
      w_valid_nxt   = r_valid;
      w_busy_nxt    = r_busy;
      w_overrun_nxt = r_overrun;
      case (r_state)
         ST_IDLE: begin
            // ack has no meaning here; only a fresh rise starts a measurement.
            w_valid_nxt = 1'b0;
            if (w_rise) begin
               w_time_nxt  = r_counter;
               w_len_nxt   = LEN_WIDTH'(1);
               w_busy_nxt  = 1'b1;
               w_state_nxt = ST_MEASURE;
            end else begin
               w_busy_nxt  = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_MEASURE: begin
            // ack is ignored while a pulse is being measured.
            if (detect) begin
               w_len_nxt   = sat_inc(r_len_out);
               w_busy_nxt  = 1'b1;
               w_state_nxt = ST_MEASURE;
            end else begin
               w_busy_nxt  = 1'b0;
               w_valid_nxt = 1'b1;
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (ack) begin
               // Result consumed; a rise in the same cycle is a legitimate new event.
               w_overrun_nxt = 1'b0;
               w_valid_nxt   = 1'b0;
               if (w_rise) begin
                  w_time_nxt  = r_counter;
                  w_len_nxt   = LEN_WIDTH'(1);
                  w_busy_nxt  = 1'b1;
                  w_state_nxt = ST_MEASURE;
               end else begin
                  w_busy_nxt  = 1'b0;
                  w_state_nxt = ST_IDLE;
               end
            end else if (w_rise) begin
               // No room for the new event: drop it and remember that we did.
               w_overrun_nxt = 1'b1;
               w_state_nxt   = ST_HOLD;
            end else begin
               w_state_nxt = ST_HOLD;
            end
         end
         default: begin
            // Unreachable encoding: recover to a clean idle state.
            w_state_nxt   = ST_IDLE;
            w_valid_nxt   = 1'b0;
            w_busy_nxt    = 1'b0;
            w_overrun_nxt = 1'b0;
         end
      endcase
   end

   // State and result registers; every output comes straight from a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_time_out <= '0;
         r_len_out  <= '0;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_time_out <= w_time_nxt;
         r_len_out  <= w_len_nxt;
         r_valid    <= w_valid_nxt;
         r_busy     <= w_busy_nxt;
         r_overrun  <= w_overrun_nxt;
      end
   end

   assign time_out = r_time_out;
   assign len_out  = r_len_out;
   assign valid    = r_valid;
   assign busy     = r_busy;
   assign overrun  = r_overrun;

endmodule : detect_timer

// File: tb/tb_detect_timer.sv
// Directed self-checking bench for detect_timer: a default-width instance and a
// narrow instance (4-bit counter, 2-bit length) to reach wrap and saturation quickly.
module tb_detect_timer;

   logic        clk;
   logic        rst;
   logic        detect;
   logic        ack;
   logic [31:0] time_out;
   logic [15:0] len_out;
   logic        valid;
   logic        busy;
   logic        overrun;

   logic        s_detect;
   logic        s_ack;
   logic [3:0]  s_time_out;
   logic [1:0]  s_len_out;
   logic        s_valid;
   logic        s_busy;
   logic        s_overrun;

   int          total;
   int          bad;
   logic [31:0] cnt;
   logic [31:0] exp_t;

   detect_timer dut (
      .clk      (clk),
      .rst      (rst),
      .detect   (detect),
      .ack      (ack),
      .time_out (time_out),
      .len_out  (len_out),
      .valid    (valid),
      .busy     (busy),
      .overrun  (overrun)
   );

   detect_timer #(.CNT_WIDTH(4), .LEN_WIDTH(2)) dut_s (
      .clk      (clk),
      .rst      (rst),
      .detect   (s_detect),
      .ack      (s_ack),
      .time_out (s_time_out),
      .len_out  (s_len_out),
      .valid    (s_valid),
      .busy     (s_busy),
      .overrun  (s_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One rising edge; cnt tracks the counter value after that edge; sample 1 ns later.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         cnt = 32'd0;
      end else begin
         cnt = cnt + 32'd1;
      end
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      cnt      = 32'd0;
      exp_t    = 32'd0;
      rst      = 1'b1;
      detect   = 1'b0;
      ack      = 1'b0;
      s_detect = 1'b0;
      s_ack    = 1'b0;
      tick();

      // Some activity, then a single reset cycle in the middle of a measurement.
      rst    = 1'b0;
      detect = 1'b1;
      tick();
      tick();
      tick();
      detect = 1'b0;
      rst    = 1'b1;
      tick();
      check("rst_counter", dut.r_counter, 32'd0);
      check("rst_time",    time_out, 32'd0);
      check("rst_len",     {16'd0, len_out}, 32'd0);
      check("rst_valid",   {31'd0, valid}, 32'd0);
      check("rst_busy",    {31'd0, busy}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("cnt_after5", dut.r_counter, 32'd5);

      // 1-cycle pulse first sampled high when the counter is 7.
      tick();
      tick();
      detect = 1'b1;
      tick();
      check("p1_busy",  {31'd0, busy}, 32'd1);
      check("p1_valid", {31'd0, valid}, 32'd0);
      detect = 1'b0;
      tick();
      check("p1_valid_h", {31'd0, valid}, 32'd1);
      check("p1_busy_l",  {31'd0, busy}, 32'd0);
      check("p1_time",    time_out, 32'd7);
      check("p1_len",     {16'd0, len_out}, 32'd1);

      // One low cycle already elapsed; a 2-cycle pulse while holding is dropped.
      detect = 1'b1;
      tick();
      check("drop_ovr_1", {31'd0, overrun}, 32'd1);
      tick();
      detect = 1'b0;
      tick();
      check("drop_ovr",   {31'd0, overrun}, 32'd1);
      check("drop_valid", {31'd0, valid}, 32'd1);
      check("drop_time",  time_out, 32'd7);
      check("drop_len",   {16'd0, len_out}, 32'd1);
      check("drop_busy",  {31'd0, busy}, 32'd0);

      // Acknowledge, then a 10-cycle pulse.
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("ack_valid",   {31'd0, valid}, 32'd0);
      check("ack_overrun", {31'd0, overrun}, 32'd0);
      check("ack_busy",    {31'd0, busy}, 32'd0);
      tick();
      detect = 1'b1;
      exp_t  = cnt;
      tick();
      check("p10_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 9; i++) tick();
      check("p10_noval", {31'd0, valid}, 32'd0);
      detect = 1'b0;
      tick();
      check("p10_valid", {31'd0, valid}, 32'd1);
      check("p10_len",   {16'd0, len_out}, 32'd10);
      check("p10_time",  time_out, exp_t);

      // Dropped pulse sets overrun; then ack together with a new rise.
      detect = 1'b1;
      tick();
      detect = 1'b0;
      tick();
      check("pre_ovr", {31'd0, overrun}, 32'd1);
      ack    = 1'b1;
      detect = 1'b1;
      exp_t  = cnt;
      tick();
      ack = 1'b0;
      check("ar_valid",   {31'd0, valid}, 32'd0);
      check("ar_busy",    {31'd0, busy}, 32'd1);
      check("ar_time",    time_out, exp_t);
      check("ar_overrun", {31'd0, overrun}, 32'd0);
      check("ar_len",     {16'd0, len_out}, 32'd1);
      tick();
      detect = 1'b0;
      tick();
      check("ar_len2",   {16'd0, len_out}, 32'd2);
      check("ar_valid2", {31'd0, valid}, 32'd1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("cnt_model", dut.r_counter, cnt);

      // Narrow instance: capture at counter 15, wrap, and length saturation.
      for (int i = 0; i < 16; i++) begin
         if (cnt[3:0] != 4'd15) tick();
      end
      s_detect = 1'b1;
      tick();
      check("w_time",    {28'd0, s_time_out}, 32'd15);
      check("w_counter", {28'd0, dut_s.r_counter}, 32'd0);
      check("w_busy",    {31'd0, s_busy}, 32'd1);
      for (int i = 0; i < 5; i++) tick();
      check("w_len_sat", {30'd0, s_len_out}, 32'd3);
      s_detect = 1'b0;
      tick();
      check("w_valid",  {31'd0, s_valid}, 32'd1);
      check("w_len",    {30'd0, s_len_out}, 32'd3);
      check("w_time2",  {28'd0, s_time_out}, 32'd15);
      check("w_ovr",    {31'd0, s_overrun}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_detect_timer
